// File: rtl/jogo_pkg.sv
// Shared definitions for the game circuit: FSM state codes, board size and
// one-hot helpers used by the button conditioner and the board logic.
package jogo_pkg;

    localparam int NUM_CELULAS = 9;

    typedef enum logic [3:0] {
        OCIOSO        = 4'd0,
        FILTRANDO     = 4'd1,
        VALIDA        = 4'd2,
        ESPERA_SOLTAR = 4'd3
    } estado_t;

    // Index of the highest set bit; for a one-hot vector this is the cell number.
    function automatic logic [3:0] onehot_para_indice(input logic [NUM_CELULAS-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CELULAS; i++) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic eh_onehot(input logic [NUM_CELULAS-1:0] v);
        logic [NUM_CELULAS-1:0] um;
        um = 1;
        return (v != '0) && ((v & (v - um)) == '0);
    endfunction

endpackage

// File: rtl/condicionador_botoes_if.sv
// Move-event bus between the button conditioner (slave) and the game FSM
// (master): raw buttons and control in, one held move out.
interface condicionador_botoes_if;
    import jogo_pkg::*;

    logic [NUM_CELULAS-1:0] botoes;
    logic                   limpa;
    logic                   aceita;
    logic                   tem_jogada;
    logic [3:0]             jogada;
    logic [NUM_CELULAS-1:0] jogada_onehot;
    logic                   erro_multiplo;
    logic [3:0]             db_estado;

    modport master (
        output botoes, limpa, aceita,
        input  tem_jogada, jogada, jogada_onehot, erro_multiplo, db_estado
    );

    modport slave (
        input  botoes, limpa, aceita,
        output tem_jogada, jogada, jogada_onehot, erro_multiplo, db_estado
    );

endinterface

// File: rtl/condicionador_botoes_sincronizador_2ff.sv
// Two-flop synchronizer per bit for bringing asynchronous inputs into the
// clock domain.
module sincronizador_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sinc_p0;
    logic [WIDTH-1:0] sinc_p1;

    // stage 0 may go metastable; stage 1 gives it a full cycle to settle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc_p0 <= '0;
            sinc_p1 <= '0;
        end else begin
            sinc_p0 <= d;
            sinc_p1 <= sinc_p0;
        end
    end

    assign q = sinc_p1;

endmodule

// File: rtl/condicionador_botoes.sv
// Turns the nine raw cell buttons into debounced, single-cell move events
// held until the game FSM accepts them.
module condicionador_botoes #(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    condicionador_botoes_if.slave bus
);
    import jogo_pkg::*;

    localparam int                 CONT_W   = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CONT_W-1:0]  CONT_MAX = CONT_W'(DEBOUNCE_CICLOS - 1);
    localparam logic [CONT_W-1:0]  CONT_UM  = 1;

    if (DEBOUNCE_CICLOS < 2) begin : g_param_invalido
        $error("DEBOUNCE_CICLOS must be at least 2");
    end

    logic [NUM_CELULAS-1:0] sinc;
    estado_t                estado, prox_estado;
    logic [NUM_CELULAS-1:0] amostra, amostra_prox;
    logic [CONT_W-1:0]      contador, contador_prox;
    logic                   fim_contagem;
    logic                   erro_evento;

    logic                   tem_r, tem_prox;
    logic [3:0]             jogada_r, jogada_prox;
    logic [NUM_CELULAS-1:0] onehot_r, onehot_prox;
    logic                   erro_r, erro_prox;

    sincronizador_2ff #(.WIDTH(NUM_CELULAS)) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (bus.botoes),
        .q     (sinc)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= OCIOSO;
            amostra  <= '0;
            contador <= '0;
        end else begin
            estado   <= prox_estado;
            amostra  <= amostra_prox;
            contador <= contador_prox;
        end
    end

    assign fim_contagem = (contador == CONT_MAX);

    // The counter is shared: stability time in FILTRANDO, release time in ESPERA_SOLTAR.
    always_comb begin
        prox_estado   = estado;
        amostra_prox  = amostra;
        contador_prox = contador;
        erro_evento   = 1'b0;
        case (estado)
            OCIOSO: begin
                if (sinc != '0) begin
                    amostra_prox  = sinc;
                    contador_prox = '0;
                    prox_estado   = FILTRANDO;
                end
            end
            FILTRANDO: begin
                if (sinc == '0) begin
                    contador_prox = '0;
                    prox_estado   = OCIOSO;
                end else if (sinc != amostra) begin
                    amostra_prox  = sinc;
                    contador_prox = '0;
                end else if (fim_contagem) begin
                    contador_prox = '0;
                    if (eh_onehot(amostra)) begin
                        prox_estado = VALIDA;
                    end else begin
                        prox_estado = ESPERA_SOLTAR;
                        erro_evento = 1'b1;
                    end
                end else begin
                    contador_prox = contador + CONT_UM;
                end
            end
            VALIDA: begin
                if (bus.aceita) begin
                    contador_prox = '0;
                    prox_estado   = ESPERA_SOLTAR;
                end
            end
            ESPERA_SOLTAR: begin
                if (sinc != '0) begin
                    contador_prox = '0;
                end else if (fim_contagem) begin
                    prox_estado = OCIOSO;
                end else begin
                    contador_prox = contador + CONT_UM;
                end
            end
            default: begin
                contador_prox = '0;
                prox_estado   = OCIOSO;
            end
        endcase
        if (bus.limpa) begin
            contador_prox = '0;
            prox_estado   = OCIOSO;
            erro_evento   = 1'b0;
        end
    end

    // Outputs are registered images of the next state, so they follow it with no extra lag.
    always_comb begin
        tem_prox    = 1'b0;
        jogada_prox = '0;
        onehot_prox = '0;
        erro_prox   = erro_evento;
        if (prox_estado == VALIDA) begin
            tem_prox = 1'b1;
            if (estado == VALIDA) begin
                jogada_prox = jogada_r;
                onehot_prox = onehot_r;
            end else begin
                jogada_prox = onehot_para_indice(amostra);
                onehot_prox = amostra;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tem_r    <= 1'b0;
            jogada_r <= '0;
            onehot_r <= '0;
            erro_r   <= 1'b0;
        end else begin
            tem_r    <= tem_prox;
            jogada_r <= jogada_prox;
            onehot_r <= onehot_prox;
            erro_r   <= erro_prox;
        end
    end

    assign bus.tem_jogada    = tem_r;
    assign bus.jogada        = jogada_r;
    assign bus.jogada_onehot = onehot_r;
    assign bus.erro_multiplo = erro_r;
    assign bus.db_estado     = estado;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes: directed scenarios plus random button
// traffic, every cycle compared against a run-length reference model.
module tb_condicionador_botoes;

    localparam int D = 4;

    logic clock = 1'b0;
    logic reset;

    condicionador_botoes_if bus ();

    condicionador_botoes #(.DEBOUNCE_CICLOS(D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int vetores = 0;
    int falhas  = 0;

    // Reference model: phase 0 idle, 1 filtering, 2 move held, 3 waiting release.
    logic [8:0] atraso [2];
    int         fase;
    logic [8:0] padrao;
    int         repet;
    int         zeros;
    logic [3:0] exp_jog;
    logic [8:0] exp_oh;
    logic       exp_erro;

    function automatic logic [18:0] observado();
        return {bus.tem_jogada, bus.jogada, bus.jogada_onehot, bus.erro_multiplo, bus.db_estado};
    endfunction

    function automatic logic [18:0] esperado();
        return {(fase == 2), exp_jog, exp_oh, exp_erro, 4'(fase)};
    endfunction

    task automatic modelo_limpa();
        atraso[0] = '0;
        atraso[1] = '0;
        fase      = 0;
        exp_jog   = '0;
        exp_oh    = '0;
        exp_erro  = 1'b0;
        repet     = 0;
        zeros     = 0;
        padrao    = '0;
    endtask

    // A pattern becomes a move once D+1 identical consecutive samples are seen;
    // release needs D consecutive empty samples after leaving the move.
    task automatic modelo_passo(input logic [8:0] s, input logic lp, input logic ac);
        exp_erro = 1'b0;
        if (lp) begin
            fase    = 0;
            exp_jog = '0;
            exp_oh  = '0;
        end else begin
            case (fase)
                0: if (s != '0) begin
                    padrao = s;
                    repet  = 1;
                    fase   = 1;
                end
                1: if (s == '0) begin
                    fase = 0;
                end else if (s != padrao) begin
                    padrao = s;
                    repet  = 1;
                end else begin
                    repet++;
                    if (repet == D + 1) begin
                        zeros = 0;
                        if ($countones(padrao) == 1) begin
                            fase    = 2;
                            exp_oh  = padrao;
                            exp_jog = 4'($clog2(padrao));
                        end else begin
                            fase     = 3;
                            exp_erro = 1'b1;
                        end
                    end
                end
                2: if (ac) begin
                    fase    = 3;
                    zeros   = 0;
                    exp_jog = '0;
                    exp_oh  = '0;
                end
                default: if (s == '0) begin
                    zeros++;
                    if (zeros == D) fase = 0;
                end else begin
                    zeros = 0;
                end
            endcase
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        modelo_passo(atraso[1], bus.limpa, bus.aceita);
        atraso[1] = atraso[0];
        atraso[0] = bus.botoes;
        #1;
        vetores++;
        assert (observado() === esperado()) else begin
            falhas++;
            $error("FAIL %s: got %h, expected %h", tag, observado(), esperado());
        end
    endtask

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vetores++;
        assert (obs === exp) else begin
            falhas++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic reset_assincrono(input string tag);
        #2 reset = 1'b0;
        #1;
        modelo_limpa();
        vetores++;
        assert (observado() === 19'h0) else begin
            falhas++;
            $error("FAIL %s: got %h, expected 0", tag, observado());
        end
        #2 reset = 1'b1;
    endtask

    task automatic espera_tem(input string tag, input int limite, output int n);
        n = -1;
        for (int i = 1; i <= limite; i++) begin
            tick(tag);
            if (bus.tem_jogada) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic espera_ocioso(input string tag, input int limite, output int n);
        n = -1;
        for (int i = 1; i <= limite; i++) begin
            tick(tag);
            if (bus.db_estado == 4'd0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic pulso_aceita(input string tag);
        bus.aceita = 1'b1;
        tick(tag);
        bus.aceita = 1'b0;
    endtask

    initial begin
        int n;
        int cnt;
        int erros;
        bus.botoes = '0;
        bus.limpa  = 1'b0;
        bus.aceita = 1'b0;
        reset      = 1'b0;
        modelo_limpa();
        #1;
        reset_assincrono("reset_inicial");

        bus.botoes = 9'h010;
        espera_tem("press", 12, n);
        confere("press_latencia", n, D + 3);
        confere("press_jogada", bus.jogada, 4);
        confere("press_onehot", bus.jogada_onehot, 9'h010);
        repeat (3) tick("press_hold");
        pulso_aceita("aceita");
        confere("aceita_tem", bus.tem_jogada, 0);
        cnt = 0;
        repeat (20) begin
            tick("segurado");
            cnt += int'(bus.tem_jogada);
        end
        confere("sem_segunda_jogada", cnt, 0);
        bus.botoes = '0;
        espera_ocioso("soltura", 20, n);
        confere("soltura_latencia", (n >= 1) && (n <= D + 2), 1);

        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            bus.botoes = ((i / 2) % 2 == 0) ? 9'h001 : 9'h000;
            tick("bounce");
            cnt += int'(bus.tem_jogada);
        end
        confere("bounce_sem_jogada", cnt, 0);
        bus.botoes = 9'h001;
        espera_tem("bounce_hold", 12, n);
        confere("bounce_uma_jogada", n > 0, 1);
        confere("bounce_jogada", bus.jogada, 0);
        pulso_aceita("bounce_aceita");
        bus.botoes = '0;
        repeat (10) tick("bounce_solta");

        bus.botoes = 9'h003;
        cnt   = 0;
        erros = 0;
        repeat (15) begin
            tick("multi");
            cnt   += int'(bus.tem_jogada);
            erros += int'(bus.erro_multiplo);
        end
        confere("multi_pulsos", erros, 1);
        confere("multi_sem_jogada", cnt, 0);
        confere("multi_estado", bus.db_estado, 3);
        bus.botoes = '0;
        repeat (8) tick("multi_solta");
        bus.botoes = 9'h100;
        espera_tem("celula8", 12, n);
        confere("celula8_latencia", n, D + 3);
        confere("celula8_jogada", bus.jogada, 8);
        pulso_aceita("celula8_aceita");
        bus.botoes = '0;
        repeat (10) tick("celula8_solta");

        bus.botoes = 9'h020;
        espera_tem("limpa_press", 12, n);
        bus.limpa  = 1'b1;
        bus.aceita = 1'b1;
        tick("limpa");
        bus.limpa  = 1'b0;
        bus.aceita = 1'b0;
        confere("limpa_tem", bus.tem_jogada, 0);
        confere("limpa_estado", bus.db_estado, 0);
        bus.botoes = '0;
        repeat (8) tick("limpa_solta");

        bus.botoes = 9'h004;
        repeat (4) tick("pre_reset");
        confere("filtrando", bus.db_estado, 1);
        reset_assincrono("reset_filtrando");
        espera_tem("pos_reset", 12, n);
        confere("pos_reset_latencia", n, D + 3);
        reset_assincrono("reset_valida");
        bus.botoes = '0;
        repeat (10) tick("pos_reset_solta");

        bus.botoes = 9'h080;
        espera_tem("gating_press", 12, n);
        cnt = 0;
        repeat (50) begin
            bus.botoes = 9'($urandom);
            tick("gating");
            if (!bus.tem_jogada || bus.jogada != 4'd7 || bus.jogada_onehot != 9'h080) cnt++;
        end
        confere("gating_estavel", cnt, 0);
        bus.aceita = 1'b1;
        bus.botoes = '0;
        tick("gating_aceita");
        bus.aceita = 1'b0;
        espera_ocioso("gating_solta", 20, n);
        confere("gating_soltura", (n >= 1) && (n <= D + 2), 1);

        for (int seg = 0; seg < 120; seg++) begin
            int         len;
            int         tipo;
            logic [8:0] p;
            tipo = $urandom_range(0, 9);
            if (tipo < 4) begin
                p = '0;
            end else if (tipo < 8) begin
                p = 9'(1) << $urandom_range(0, 8);
            end else begin
                p = 9'($urandom);
                if ($countones(p) < 2) p = p | 9'h011;
            end
            len = $urandom_range(1, 9);
            bus.botoes = p;
            for (int c = 0; c < len; c++) begin
                bus.aceita = ($urandom_range(0, 3) == 0);
                bus.limpa  = ($urandom_range(0, 39) == 0);
                tick("aleatorio");
            end
        end
        bus.botoes = '0;
        bus.aceita = 1'b0;
        bus.limpa  = 1'b0;
        repeat (10) tick("final");

        $display("== %0d vectors applied, %0d miscompares ==", vetores, falhas);
        $finish;
    end

endmodule
